// File: rtl/cross_bar_pkg.sv
// Shared types for the crossbar and its slave endpoints.
// Holds the default bus widths, command encoding and slave FSM states.
package cross_bar_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } slave_state_e;

endpackage

// File: rtl/cross_bar_sram.sv
// Single-port synchronous word RAM with a one-cycle registered read.
// Contents are deliberately not reset.
module cross_bar_sram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read-before-write: a same-edge write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
        r_rdata <= r_mem[idx];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/cross_bar_slave_ram.sv
// RAM-backed crossbar slave: captures a request, waits WAIT_CYCLES,
// then performs the word access and pulses ack for one cycle.
module cross_bar_slave_ram
    import cross_bar_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    slave_state_e      r_state;
    slave_state_e      w_nextState;
    logic [3:0]        r_count;
    logic [IDX_W-1:0]  r_idx;
    cmd_e              r_cmd;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdHold;
    logic              r_ack;

    logic [IDX_W-1:0]  w_reqIdx;
    logic [IDX_W-1:0]  w_ramIdx;
    logic              w_ramWe;
    logic [DATA_W-1:0] w_ramRdata;
    logic              w_unusedAddrBits;

    assign w_reqIdx         = addr[IDX_W+1:2];
    assign w_unusedAddrBits = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_nextState = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (r_count <= 4'd1) begin
                    w_nextState = ACK;
                end
            end
            ACK:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_idx    <= '0;
            r_cmd    <= CMD_READ;
            r_wdata  <= '0;
            r_ack    <= 1'b0;
            r_rdHold <= '0;
        end else begin
            r_state <= w_nextState;
            r_ack   <= (w_nextState == ACK);
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_idx   <= w_reqIdx;
                        r_cmd   <= cmd_e'(cmd);
                        r_wdata <= wdata;
                        r_count <= WAIT_INIT;
                    end
                end
                WAIT: r_count <= r_count - 4'd1;
                ACK: begin
                    if (r_cmd == CMD_READ) begin
                        r_rdHold <= w_ramRdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // While idle the RAM reads the live request index so a zero-wait read lands at ACK.
    assign w_ramIdx = (r_state == IDLE) ? w_reqIdx : r_idx;
    assign w_ramWe  = (r_state == ACK) && (r_cmd == CMD_WRITE) && !rst;

    cross_bar_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (w_ramWe),
        .idx   (w_ramIdx),
        .wdata (r_wdata),
        .rdata (w_ramRdata)
    );

    // The RAM read register is shown directly during a read ACK, otherwise the held value.
    assign rdata = (r_state == ACK && r_cmd == CMD_READ) ? w_ramRdata : r_rdHold;
    assign ack   = r_ack;

endmodule

// File: tb/tb_cross_bar_slave_ram.sv
// Directed bench for cross_bar_slave_ram with a 2-wait instance (A) and a
// zero-wait instance (B); cycle 0 is the cycle the request is first driven.
module tb_cross_bar_slave_ram;

    logic        clk;
    logic        rst;
    logic        reqA, cmdA, ackA;
    logic [31:0] addrA, wdataA, rdataA;
    logic        reqB, cmdB, ackB;
    logic [31:0] addrB, wdataB, rdataB;

    int checks;
    int errors;

    cross_bar_slave_ram #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)
    ) dutA (
        .clk(clk), .rst(rst), .req(reqA), .addr(addrA), .cmd(cmdA),
        .wdata(wdataA), .ack(ackA), .rdata(rdataA)
    );

    cross_bar_slave_ram #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)
    ) dutB (
        .clk(clk), .rst(rst), .req(reqB), .addr(addrB), .cmd(cmdB),
        .wdata(wdataB), .ack(ackB), .rdata(rdataB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one transaction on A and observes 10 cycles, sampling 1ns after each edge.
    task automatic applyStimulus(input logic c, input logic [31:0] a, input logic [31:0] d,
                                 input bit pulse, input bit mutate,
                                 output int ackCyc, output int ackCnt, output logic [31:0] rd);
        reqA = 1'b1; cmdA = c; addrA = a; wdataA = d;
        ackCyc = -1; ackCnt = 0; rd = '0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (pulse) reqA = 1'b0;
            if (mutate && cyc == 1) begin
                addrA  = a ^ 32'h10;
                wdataA = 32'h99;
            end
            if (ackA) begin
                ackCnt++;
                if (ackCyc < 0) begin
                    ackCyc = cyc;
                    rd = rdataA;
                end
                reqA = 1'b0;
            end
        end
        reqA = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqA = 0; cmdA = 0; addrA = 0; wdataA = 0;
        reqB = 0; cmdB = 0; addrB = 0; wdataB = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ackA !== 1'b0) begin errors++; $display("[TB] FAIL reset_ackA got %b expected 0", ackA); end
        checks++; if (rdataA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdataA got %h expected 0", rdataA); end
        checks++; if (ackB !== 1'b0) begin errors++; $display("[TB] FAIL reset_ackB got %b expected 0", ackB); end
        checks++; if (rdataB !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdataB got %h expected 0", rdataB); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int cyc, cnt;
        logic [31:0] rd;
        applyStimulus(1'b1, 32'hC000_0010, 32'h5, 0, 0, cyc, cnt, rd);
        checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL wr_ack_cycle got %0d expected 3", cyc); end
        checks++; if (cnt !== 1) begin errors++; $display("[TB] FAIL wr_ack_count got %0d expected 1", cnt); end
        applyStimulus(1'b0, 32'hC000_0010, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL rd_ack_cycle got %0d expected 3", cyc); end
        checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL rd_data got %h expected 5", rd); end
        applyStimulus(1'b1, 32'h0000_0014, 32'h6, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL rdata_hold_on_write got %h expected 5", rd); end
    endtask

    task automatic test_alias();
        int cyc, cnt;
        logic [31:0] rd;
        applyStimulus(1'b1, 32'h4000_0020, 32'h0000_000A, 0, 0, cyc, cnt, rd);
        applyStimulus(1'b0, 32'hC000_0023, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h0000_000A) begin errors++; $display("[TB] FAIL alias_sel got %h expected a", rd); end
        applyStimulus(1'b1, 32'h0000_0400, 32'h0000_5A5A, 0, 0, cyc, cnt, rd);
        applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h0000_5A5A) begin errors++; $display("[TB] FAIL alias_depth got %h expected 5a5a", rd); end
    endtask

    task automatic test_reset_mid();
        int cyc, cnt, lateAcks;
        logic [31:0] rd;
        applyStimulus(1'b1, 32'h0000_0010, 32'h11, 0, 0, cyc, cnt, rd);
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h11) begin errors++; $display("[TB] FAIL pre_reset_read got %h expected 11", rd); end
        reqA = 1'b1; cmdA = 1'b1; addrA = 32'h10; wdataA = 32'h22;
        @(posedge clk); #1;
        rst = 1'b1; reqA = 1'b0;
        @(posedge clk); #1;
        checks++; if (ackA !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ack got %b expected 0", ackA); end
        checks++; if (rdataA !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_rdata got %h expected 0", rdataA); end
        rst = 1'b0;
        lateAcks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (ackA) lateAcks++;
        end
        checks++; if (lateAcks !== 0) begin errors++; $display("[TB] FAIL mid_reset_late_ack got %0d expected 0", lateAcks); end
        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h11) begin errors++; $display("[TB] FAIL mid_reset_ram got %h expected 11", rd); end
    endtask

    task automatic test_abort();
        int cyc, cnt;
        logic [31:0] rd;
        applyStimulus(1'b1, 32'h0000_0030, 32'h33, 1, 0, cyc, cnt, rd);
        checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL abort_ack_cycle got %0d expected 3", cyc); end
        checks++; if (cnt !== 1) begin errors++; $display("[TB] FAIL abort_ack_count got %0d expected 1", cnt); end
        applyStimulus(1'b0, 32'h0000_0030, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h33) begin errors++; $display("[TB] FAIL abort_read got %h expected 33", rd); end
    endtask

    task automatic test_latch();
        int cyc, cnt;
        logic [31:0] rd;
        applyStimulus(1'b1, 32'h0000_0050, 32'h55, 0, 0, cyc, cnt, rd);
        applyStimulus(1'b1, 32'h0000_0040, 32'h44, 0, 1, cyc, cnt, rd);
        checks++; if (cyc !== 3) begin errors++; $display("[TB] FAIL latch_ack_cycle got %0d expected 3", cyc); end
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h44) begin errors++; $display("[TB] FAIL latch_captured got %h expected 44", rd); end
        applyStimulus(1'b0, 32'h0000_0050, 32'h0, 0, 0, cyc, cnt, rd);
        checks++; if (rd !== 32'h55) begin errors++; $display("[TB] FAIL latch_other got %h expected 55", rd); end
    endtask

    task automatic test_wait0();
        logic [7:0]  hist;
        logic [31:0] rd;
        reqB = 1'b1; cmdB = 1'b1; addrB = 32'h8; wdataB = 32'h77;
        @(posedge clk); #1;
        checks++; if (ackB !== 1'b1) begin errors++; $display("[TB] FAIL w0_write_ack got %b expected 1", ackB); end
        reqB = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reqB = 1'b1; cmdB = 1'b0; addrB = 32'h8; wdataB = 32'h0;
        hist = '0; rd = '0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(posedge clk); #1;
            hist[cyc] = ackB;
            if (cyc == 1) rd = rdataB;
            if (cyc == 3) reqB = 1'b0;
        end
        checks++; if (hist !== 8'b0000_1010) begin errors++; $display("[TB] FAIL w0_ack_pattern got %b expected 00001010", hist); end
        checks++; if (rd !== 32'h77) begin errors++; $display("[TB] FAIL w0_read got %h expected 77", rd); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_alias();
        test_reset_mid();
        test_abort();
        test_latch();
        test_wait0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cross_bar_slave_ram.md
# cross_bar_slave_ram

Memory-backed slave endpoint that sits directly downstream of `cross_bar`, on one of its four slave ports. It accepts a granted request (`req`/`addr`/`cmd`/`wdata`), inserts a programmable number of wait states and performs a word write or read on an internal single-port RAM. It then returns a one-cycle `ack` with `rdata`. It is used both as the synthesizable on-chip RAM slave and as the reference responder in crossbar benches.

## Interface
- `ADDR_W`, 32: address width, matches the crossbar address.
- `DATA_W`, 32: data width.
- `DEPTH`, 256: RAM depth in words; power of two, ≥2.
- `WAIT_CYCLES`, 2: wait states between request capture and `ack`; range 0..15.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  1  request from crossbar slave port.
- `addr`  in  ADDR_W  byte address; bits [ADDR_W-1:ADDR_W-2] are the crossbar slave select and are ignored here.
- `cmd`  in  1  1 = write, 0 = read.
- `wdata`  in  DATA_W  write data.
- `ack`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_W  read data, valid in the `ack` cycle.

## Operation
- Word index: `IDX = addr[$clog2(DEPTH)+1:2]`. Bits [1:0] and all bits above the index are ignored, so addresses alias modulo DEPTH×4 bytes.
- FSM states and transitions:
  - IDLE: on `req`=1, latch `addr`, `cmd` and `wdata`, and load the wait counter with WAIT_CYCLES. Go to WAIT, or straight to ACK if WAIT_CYCLES=0.
  - WAIT: decrement the counter each cycle. When the counter is 1, go to ACK.
  - ACK: `ack`=1 for exactly one cycle, then go to IDLE unconditionally.
- The access uses the latched values only. Changes on `req`/`addr`/`cmd`/`wdata` after capture have no effect.
- Write: the RAM is written on the clock edge leaving ACK. `rdata` is unchanged by writes.
- Read: `rdata` is updated on the edge entering ACK with RAM[IDX], and holds its value until the next read completes.
- Aborts are not supported. If `req` drops during WAIT, the transaction still completes and `ack` still pulses.
- After ACK the FSM always spends one cycle in IDLE. A `req` still high in that cycle is treated as a new transaction.
- RAM contents are not cleared by reset. Reads of never-written words return X in simulation.

## Timing
- Reset values: state=IDLE, `ack`=0, `rdata`=0, counter=0.
- If `req` is first high in cycle 0 (sampled at the edge ending cycle 0), `ack` is high in cycle WAIT_CYCLES+1.
- Minimum spacing between two acks is WAIT_CYCLES+2 cycles.
- `rst` asserted in any state: at the next edge return to IDLE with `ack`=0 and `rdata`=0. A pending write is dropped and the RAM is left unchanged. `rst` has priority over `req`.
- `ack` and `rdata` are registered outputs. There is no combinational path from inputs to outputs.

## Structure
- Shared package `cross_bar_pkg`:
  - ADDR_W/DATA_W defaults.
  - `cmd_e` enum with CMD_READ=0 and CMD_WRITE=1.
  - `slave_state_e` enum with IDLE, WAIT and ACK.
- Sub-module `cross_bar_sram`: single-port synchronous RAM with `clk`, `we`, `idx`, `wdata` and `rdata`, and one-cycle read latency. The FSM issues the read one cycle before ACK so that `rdata` lands exactly at ACK. For WAIT_CYCLES=0 the read is issued at capture.
- The top level contains the FSM, the capture registers and the wait counter.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - Stimulus: `req`=1 with `addr`=0xC000_0010, `cmd`=1, `wdata`=5, held until `ack`.
  - Required: `ack` high only in cycle 3.
  - Then a read of 0xC000_0010 returns `rdata`=5 in its ack cycle.
- WAIT_CYCLES=0: a read request in cycle 0 gives `ack` in cycle 1. A request held high across the ack gives a second `ack` at cycle 3, not earlier.
- Aliasing:
  - Write 0x0000_000A to 0x4000_0020, then read 0xC000_0023 → 0x0000_000A.
  - With DEPTH=256, write to 0x0000_0400, then read 0x0000_0000 → same value.
- Reset mid-operation: write 0x11 to index 4, then start a write of 0x22 to index 4 and assert `rst` in the WAIT cycle. Required: no `ack`, `rdata`=0, and a subsequent read of index 4 returns 0x11.
- Abort ignored: `req` pulses for one cycle with a write of 0x33. Required: `ack` still pulses in cycle WAIT_CYCLES+1, and a later read returns 0x33.
- Latch check: change `addr`/`wdata` during WAIT. Required: the write lands at the originally captured index with the captured data.
